// File: rtl/truth_table_pkg.sv
// truth_table_pkg: shared types and constants for the truth-table sweep sequencer
// and its evaluator golden masks.
package truth_table_pkg;
   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURE, S_DONE} state_t;
   localparam int N_MINTERMS = 16;
   localparam int IDX_W = 4;
   // F1 is minterms 1,2,3,6,11,12,14,15; F2 is the same function written as maxterms.
   localparam logic [N_MINTERMS-1:0] GOLD_F1 = 16'hD84E;
   localparam logic [N_MINTERMS-1:0] GOLD_F2 = 16'hD84E;
endpackage

// File: rtl/sweep_settle_timer.sv
// sweep_settle_timer: loadable down-counter with a zero flag, shared by the
// lab-board sequencers to time settle windows.
module sweep_settle_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);
   logic [W-1:0] cnt;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt <= '0;
      else if (load) cnt <= load_val;
      else if (cnt != '0) cnt <= cnt - 1'b1;
   end
   assign zero = (cnt == '0);
endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: walks {w,x,y,z} through all 16 minterms, captures F1/F2
// after a settle delay and compares the truth tables with masks latched at start.
module truth_table_sweeper
   import truth_table_pkg::*;
#(
   parameter int SETTLE = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [N_MINTERMS-1:0] exp_f1,
   input  logic [N_MINTERMS-1:0] exp_f2,
   output logic                  w,
   output logic                  x,
   output logic                  y,
   output logic                  z,
   input  logic                  f1_in,
   input  logic                  f2_in,
   output logic                  busy,
   output logic                  done,
   output logic [N_MINTERMS-1:0] f1_table,
   output logic [N_MINTERMS-1:0] f2_table,
   output logic                  pass,
   output logic [IDX_W-1:0]      fail_idx
);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(N_MINTERMS - 1);
   localparam logic [IDX_W-1:0] SETTLE_LOAD = (SETTLE == 0) ? '0 : IDX_W'(SETTLE - 1);
   localparam state_t ENTRY = (SETTLE == 0) ? S_CAPTURE : S_SETTLE;
   state_t                state;
   logic [IDX_W-1:0]      idx;
   logic [N_MINTERMS-1:0] e1, e2, f1_nxt, f2_nxt, mis;
   logic [IDX_W-1:0]      lo;
   logic                  load, zero;
   assign load = (state == S_IDLE && start) || (state == S_CAPTURE && idx != LAST);
   sweep_settle_timer #(.W(IDX_W)) u_timer (
      .clk(clk),
      .rst_n(rst_n),
      .load(load),
      .load_val(SETTLE_LOAD),
      .zero(zero)
   );
   // Verdict is taken on the tables including the bit captured at the final edge.
   always_comb begin
      f1_nxt = f1_table;
      f1_nxt[idx] = f1_in;
      f2_nxt = f2_table;
      f2_nxt[idx] = f2_in;
      mis = (f1_nxt ^ e1) | (f2_nxt ^ e2);
      lo = '0;
      for (int i = N_MINTERMS - 1; i >= 0; i--) if (mis[i]) lo = IDX_W'(i);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         idx <= '0;
         busy <= 1'b0;
         done <= 1'b0;
         f1_table <= '0;
         f2_table <= '0;
         pass <= 1'b0;
         fail_idx <= '0;
         e1 <= '0;
         e2 <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: if (start) begin
               e1 <= exp_f1;
               e2 <= exp_f2;
               idx <= '0;
               f1_table <= '0;
               f2_table <= '0;
               pass <= 1'b0;
               fail_idx <= '0;
               busy <= 1'b1;
               state <= ENTRY;
            end
            S_SETTLE: if (zero) state <= S_CAPTURE;
            S_CAPTURE: begin
               f1_table <= f1_nxt;
               f2_table <= f2_nxt;
               if (idx == LAST) begin
                  done <= 1'b1;
                  pass <= (mis == '0);
                  fail_idx <= lo;
                  state <= S_DONE;
               end else begin
                  idx <= idx + 1'b1;
                  state <= ENTRY;
               end
            end
            default: begin
               busy <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end
   assign {w, x, y, z} = idx;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: drives a SETTLE=1 and a SETTLE=0 sweeper against
// behavioural evaluators and checks cycle timing and verdicts against a reference model.
module tb_truth_table_sweeper;
   localparam logic [15:0] GOLD = 16'hD84E;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [1:0] start = '0;
   logic [1:0][15:0] exp1, exp2, tt1, tt2, f1t, f2t;
   logic [1:0][3:0] mt, fidx;
   logic [1:0] busy, done, pass;
   int n_vec = 0;
   int n_err = 0;
   always #5 clk = ~clk;
   // Instance 0 settles one cycle per minterm, instance 1 none.
   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic w, x, y, z;
      assign mt[g] = {w, x, y, z};
      truth_table_sweeper #(.SETTLE(1 - g)) dut (
         .clk(clk), .rst_n(rst_n), .start(start[g]),
         .exp_f1(exp1[g]), .exp_f2(exp2[g]),
         .w(w), .x(x), .y(y), .z(z),
         .f1_in(tt1[g][mt[g]]), .f2_in(tt2[g][mt[g]]),
         .busy(busy[g]), .done(done[g]),
         .f1_table(f1t[g]), .f2_table(f2t[g]),
         .pass(pass[g]), .fail_idx(fidx[g])
      );
   end
   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask
   function automatic logic [3:0] lowest(input logic [15:0] m);
      logic [15:0] iso;
      iso = m & (~m + 16'd1);
      return (m == 16'd0) ? 4'd0 : 4'($clog2(iso));
   endfunction
   // Called at the negedge after the start edge; ends at the first idle negedge.
   // mode 0: plain, 1: start re-pulsed at minterms 3, 15 and in DONE, 2: start held.
   task automatic watch(input int d, input logic [15:0] e1, input logic [15:0] e2, input int mode);
      int per, last;
      logic [15:0] mis;
      per = 2 - d;
      last = 16 * per;
      mis = (tt1[d] ^ e1) | (tt2[d] ^ e2);
      for (int k = 0; k <= last + 1; k++) begin
         check("idx", 16'(mt[d]), 16'(k >= last ? 15 : k / per));
         check("busy", 16'(busy[d]), 16'(k <= last));
         check("done", 16'(done[d]), 16'(k == last));
         if (k >= last) begin
            check("f1_table", f1t[d], tt1[d]);
            check("f2_table", f2t[d], tt2[d]);
            check("pass", 16'(pass[d]), 16'(mis == 16'd0));
            check("fail_idx", 16'(fidx[d]), 16'(lowest(mis)));
         end
         start[d] = (mode == 2) || (mode == 1 && (k == 3 * per || k == 15 * per || k == last));
         if (k < last && $urandom_range(0, 2) == 0) begin
            exp1[d] = 16'($urandom);
            exp2[d] = 16'($urandom);
         end else if (k == last) begin
            exp1[d] = e1;
            exp2[d] = e2;
         end
         if (k <= last) @(negedge clk);
      end
   endtask
   task automatic sweep(input int d, input logic [15:0] e1, input logic [15:0] e2, input int mode);
      @(negedge clk);
      exp1[d] = e1;
      exp2[d] = e2;
      start[d] = 1'b1;
      @(negedge clk);
      watch(d, e1, e2, mode);
   endtask
   task automatic check_reset_values(input int d);
      check("rst_idx", 16'(mt[d]), 16'd0);
      check("rst_busy", 16'(busy[d]), 16'd0);
      check("rst_done", 16'(done[d]), 16'd0);
      check("rst_f1_table", f1t[d], 16'd0);
      check("rst_f2_table", f2t[d], 16'd0);
      check("rst_pass", 16'(pass[d]), 16'd0);
      check("rst_fail_idx", 16'(fidx[d]), 16'd0);
   endtask
   initial begin
      exp1 = '0;
      exp2 = '0;
      tt1 = {GOLD, GOLD};
      tt2 = {GOLD, GOLD};
      repeat (2) @(negedge clk);
      check_reset_values(0);
      check_reset_values(1);
      rst_n = 1'b1;
      // Golden and injected-fault sweeps with settle.
      sweep(0, GOLD, GOLD, 0);
      sweep(0, 16'hD84F, GOLD, 0);
      sweep(0, GOLD, 16'hD04E, 0);
      // Zero settle: one minterm per cycle.
      sweep(1, GOLD, GOLD, 0);
      sweep(1, GOLD ^ 16'h0100, GOLD, 0);
      // Start abuse: re-pulses are ignored and nothing restarts after DONE.
      sweep(0, GOLD, GOLD, 1);
      @(negedge clk);
      check("no_restart", 16'(busy[0]), 16'd0);
      // Start held high: back-to-back sweeps, one idle cycle between.
      for (int d = 0; d < 2; d++) begin
         sweep(d, GOLD, GOLD, 2);
         @(negedge clk);
         watch(d, GOLD, GOLD, 0);
      end
      // Stuck-at-0 F2 evaluator output.
      tt2[0] = 16'd0;
      sweep(0, GOLD, GOLD, 0);
      check("stuck_fail_idx", 16'(fidx[0]), 16'd1);
      tt2[0] = GOLD;
      // Reset at minterm 7.
      @(negedge clk);
      exp1[0] = GOLD;
      exp2[0] = GOLD;
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      for (int i = 0; i < 100 && mt[0] != 4'd7; i++) @(negedge clk);
      check("reach_minterm7", 16'(mt[0]), 16'd7);
      rst_n = 1'b0;
      #1;
      check_reset_values(0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("rst_no_done", 16'(done[0]), 16'd0);
      end
      rst_n = 1'b1;
      sweep(0, GOLD, GOLD, 0);
      check("post_rst_pass", 16'(pass[0]), 16'd1);
      // Random evaluator functions with random or near-matching masks.
      for (int n = 0; n < 12; n++) begin
         int d;
         logic [15:0] e1, e2;
         d = int'($urandom_range(0, 1));
         tt1[d] = 16'($urandom);
         tt2[d] = 16'($urandom);
         e1 = tt1[d];
         e2 = tt2[d];
         case ($urandom_range(0, 3))
            0: ;
            1: e1 = e1 ^ (16'd1 << $urandom_range(0, 15));
            2: e2 = e2 ^ (16'd1 << $urandom_range(0, 15));
            default: begin
               e1 = 16'($urandom);
               e2 = 16'($urandom);
            end
         endcase
         sweep(d, e1, e2, int'($urandom_range(0, 1)));
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
